// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 key decoder: folds E0/F0/E1 prefixes into one key event,
// tracks shift/ctrl/alt and queues events in a FIFO read over an 8-bit CPU bus.
module ps2_key_decoder #(
   parameter int DEPTH_LOG2 = 3,
   parameter int SKIP_LEN   = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_perr,
   inout  wire  [7:0] d,
   input  logic       n_oe,
   input  logic       n_we,
   input  logic       n_sel,
   input  logic       a,
   output logic       n_irq
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = (SKIP_LEN < 1) ? 1 : $clog2(SKIP_LEN + 1);

   typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_SKIP} state_t;

   state_t                state, state_next;
   logic [CW-1:0]         skip_cnt, cnt_next;
   logic                  push;
   logic [9:0]            push_ev;

   logic [9:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]   count, count_next;
   logic                  ovf, perr;
   logic                  shift_l, shift_r, ctrl_l, ctrl_r, alt_l, alt_r;
   logic                  rd_q, wr_q;

   wire rx_bad  = rx_valid & rx_perr;
   wire is_sys  = (rx_data == 8'hFA) || (rx_data == 8'hAA) || (rx_data == 8'hEE) ||
                  (rx_data == 8'hFC) || (rx_data == 8'hFE) || (rx_data == 8'h00) ||
                  (rx_data == 8'hFF);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         skip_cnt <= '0;
      end else begin
         state    <= state_next;
         skip_cnt <= cnt_next;
      end
   end

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      cnt_next   = skip_cnt;
      if (rx_bad) begin
         state_next = S_IDLE;
         cnt_next   = '0;
      end else if (rx_valid) begin
         unique case (state)
            S_IDLE: begin
               if (rx_data == 8'hE0)      state_next = S_EXT;
               else if (rx_data == 8'hF0) state_next = S_BRK;
               else if (rx_data == 8'hE1) begin
                  state_next = S_SKIP;
                  cnt_next   = CW'(SKIP_LEN);
               end
            end
            S_EXT:            state_next = (rx_data == 8'hF0) ? S_EXTBRK : S_IDLE;
            S_BRK, S_EXTBRK:  state_next = S_IDLE;
            S_SKIP: begin
               cnt_next = skip_cnt - CW'(1);
               if (skip_cnt == CW'(1)) state_next = S_IDLE;
            end
            default:          state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      push    = 1'b0;
      push_ev = {2'b00, rx_data};
      if (rx_valid && !rx_perr) begin
         unique case (state)
            S_IDLE: if (rx_data != 8'hE0 && rx_data != 8'hF0 && rx_data != 8'hE1) begin
               push    = 1'b1;
               push_ev = {is_sys, is_sys, rx_data};
            end
            S_EXT: if (rx_data != 8'hF0) begin
               push    = 1'b1;
               push_ev = {2'b10, rx_data};
            end
            S_BRK: begin
               push    = 1'b1;
               push_ev = {2'b01, rx_data};
            end
            S_EXTBRK: begin
               push    = 1'b1;
               push_ev = {2'b11, rx_data};
            end
            S_SKIP: if (skip_cnt == CW'(1)) begin
               push    = 1'b1;
               push_ev = {2'b10, 8'hE1};
            end
            default: ;
         endcase
      end
   end

   // Bus handshake: pop at the end of a data read, control writes edge-detected.
   wire rd_act  = ~n_oe & ~n_sel & ~a;
   wire wr_act  = ~n_we & ~n_sel & a;
   wire wr_stb  = wr_act & ~wr_q;
   wire flush   = wr_stb & d[0];
   wire clr     = wr_stb & d[1];
   wire empty   = (count == '0);
   wire full    = (count == (DEPTH_LOG2 + 1)'(DEPTH));
   wire pop     = rd_q & ~rd_act & ~empty;
   wire push_ok = push & (~full | pop) & ~flush;

   always_comb begin
      if (flush) count_next = '0;
      else       count_next = count + (DEPTH_LOG2 + 1)'(push_ok) - (DEPTH_LOG2 + 1)'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ovf     <= 1'b0;
         perr    <= 1'b0;
         shift_l <= 1'b0;
         shift_r <= 1'b0;
         ctrl_l  <= 1'b0;
         ctrl_r  <= 1'b0;
         alt_l   <= 1'b0;
         alt_r   <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         n_irq   <= 1'b1;
      end else begin
         rd_q  <= rd_act;
         wr_q  <= wr_act;
         count <= count_next;
         n_irq <= (count_next == '0);
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
         end
         if (clr) begin
            ovf  <= 1'b0;
            perr <= 1'b0;
         end
         if (push && full && !pop && !flush) ovf <= 1'b1;
         if (rx_bad) perr <= 1'b1;
         // Modifiers track the decoded event even when the FIFO drops it.
         if (push) begin
            unique case ({push_ev[9], push_ev[7:0]})
               {1'b0, 8'h12}: shift_l <= ~push_ev[8];
               {1'b0, 8'h59}: shift_r <= ~push_ev[8];
               {1'b0, 8'h14}: ctrl_l  <= ~push_ev[8];
               {1'b1, 8'h14}: ctrl_r  <= ~push_ev[8];
               {1'b0, 8'h11}: alt_l   <= ~push_ev[8];
               {1'b1, 8'h11}: alt_r   <= ~push_ev[8];
               default: ;
            endcase
         end
      end
   end

   // NOTE: storage is not reset; entries are only observed through a non-empty head.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_ev;
   end

   wire [9:0] head     = mem[rd_ptr];
   wire       nonempty = ~empty;
   wire [7:0] status   = {nonempty, nonempty & head[9], nonempty & head[8], ovf, perr,
                          shift_l | shift_r, ctrl_l | ctrl_r, alt_l | alt_r};
   wire [7:0] rd_data  = a ? status : (nonempty ? head[7:0] : 8'h00);

   assign d = (~n_oe & ~n_sel) ? rd_data : 8'bz;

endmodule
